uart_program_loader: RTL and testbench

// Boot-time program writer for the arty_s7 top: receives a program image over UART (8N1)
// and writes it word-by-word into the instruction/data RAM write port.
// The CPU is held in reset until the last word has been written.

---
 rtl/uart_program_loader.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
//
// Boot-time program writer. Receives a program image over an 8N1 UART line
// and writes it word by word into the instruction/data RAM write port. The
// CPU is held in reset until the final word has been written.
//
// Image format (all little-endian):
//   byte 0..1 : 16-bit word count N
//   then N words of 4 bytes each, first byte = bits [7:0]
//
// Ports
//   clk        system clock, single domain
//   reset      asynchronous, active-high reset
//   rx         UART receive line, idle high, asynchronous to clk
//   mem_we     one-cycle RAM write strobe
//   mem_addr   RAM word address (valid while mem_we is high)
//   mem_wdata  RAM write data   (valid while mem_we is high)
//   cpu_reset  high until the load completes; drives the core reset
//   done       load complete, sticky until reset
//   frame_err  a stop bit was sampled low, sticky until reset
//
// CLKS_PER_BIT must be >= 4 so that the half-bit start check and the
// per-bit counter both have room to count.
// ---------------------------------------------------------------------------
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_DONE,
        LD_ERROR
    } ld_state_e;

    // -----------------------------------------------------------------------
    // rx synchronizer. Both flops reset high so a reset never looks like a
    // start bit.
    // -----------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Byte receiver
    // -----------------------------------------------------------------------
    rx_state_e        rx_state_q,   rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q,    clk_cnt_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [7:0]       shift_q,      shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             stop_err_q,   stop_err_d;
    logic             frame_err_q,  frame_err_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case statement can leave it unassigned (no latches).
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        frame_err_d  = frame_err_q;

        unique case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line half a bit in; a high level means the
                // falling edge was a glitch.
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        stop_err_d  = 1'b1;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Loader. shift_q holds the received byte while byte_valid_q is high and
    // stays stable until the next byte's data bits begin.
    // -----------------------------------------------------------------------
    ld_state_e             ld_state_q,   ld_state_d;
    logic [7:0]            len_lo_q,     len_lo_d;
    logic [15:0]           words_left_q, words_left_d;
    logic [1:0]            byte_cnt_q,   byte_cnt_d;
    logic [DATA_WIDTH-1:0] word_q,       word_d;
    logic                  mem_we_q,     mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic                  cpu_reset_q,  cpu_reset_d;
    logic                  done_q,       done_d;
    logic [15:0]           len_word;

    assign len_word = {shift_q, len_lo_q};

    always_comb begin
        ld_state_d   = ld_state_q;
        len_lo_d     = len_lo_q;
        words_left_d = words_left_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        done_d       = done_q;

        unique case (ld_state_q)
            LD_LEN_LO: begin
                if (byte_valid_q) begin
                    len_lo_d   = shift_q;
                    ld_state_d = LD_LEN_HI;
                end
            end
            LD_LEN_HI: begin
                if (byte_valid_q) begin
                    words_left_d = len_word;
                    byte_cnt_d   = '0;
                    if (len_word == 16'd0) begin
                        ld_state_d  = LD_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        ld_state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                // Bookkeeping for the write issued last cycle: the address
                // only moves after the strobe so it is stable while mem_we=1.
                if (mem_we_q) begin
                    mem_addr_d   = mem_addr_q + 1'b1;
                    words_left_d = words_left_q - 1'b1;
                    if (words_left_q == 16'd1) begin
                        ld_state_d  = LD_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end
                end
                if (byte_valid_q) begin
                    // Little-endian assembly: after four shifts the first
                    // byte sits in bits [7:0].
                    word_d     = {shift_q, word_q[DATA_WIDTH-1:8]};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {shift_q, word_q[DATA_WIDTH-1:8]};
                    end
                end
            end
            LD_DONE, LD_ERROR: begin
                // Terminal until reset; received bytes are ignored.
            end
            default: ld_state_d = LD_ERROR;
        endcase

        // A framing error aborts an unfinished load. A finished load is left
        // alone so the running CPU is not disturbed.
        if (stop_err_q && ld_state_q != LD_DONE) begin
            ld_state_d = LD_ERROR;
            mem_we_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state_q   <= LD_LEN_LO;
            len_lo_q     <= '0;
            words_left_q <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            ld_state_q   <= ld_state_d;
            len_lo_q     <= len_lo_d;
            words_left_q <= words_left_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_program_loader
//
// Directed bench: drives serial bytes on rx, logs every mem_we pulse at the
// falling clock edge and compares against hand-computed images.
// ---------------------------------------------------------------------------
module tb_uart_program_loader;

    localparam int CPB = 16;
    localparam int AW  = 14;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          frame_err;

    int total = 0;
    int bad   = 0;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .done     (done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled away from the active edge.
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int   last_we_cyc   = -1;
    int   done_rise_cyc = -1;
    logic cpu_reset_at_rise = 1'b1;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            last_we_cyc = cyc;
        end
        if (done && !done_prev) begin
            done_rise_cyc     = cyc;
            cpu_reset_at_rise = cpu_reset;
        end
        done_prev = done;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        last_we_cyc   = -1;
        done_rise_cyc = -1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        clear_log();
        @(negedge clk);
    endtask

    task automatic wait_bits(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        wait_bits(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bits(CPB);
        end
        rx = stop_ok;
        wait_bits(CPB);
        rx = 1'b1;
        wait_bits(2 * CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !done; i++) @(posedge clk);
        @(negedge clk);
        check(tag, done, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},    mem_we,    0);
        check({tag, "_addr"},  mem_addr,  0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_cpurst"}, cpu_reset, 1);
        check({tag, "_done"},  done,      0);
        check({tag, "_ferr"},  frame_err, 0);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // 1: reset only, idle line
        check_reset_values("rst");
        repeat (10000) @(posedge clk);
        @(negedge clk);
        check("idle_writes", wr_addr.size(), 0);
        check("idle_cpurst", cpu_reset, 1);
        check("idle_done",   done, 0);

        // 2: two-word image
        pulse_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h0000_0013);
        check("two_mid_done", done, 0);
        check("two_mid_cpurst", cpu_reset, 1);
        send_word(32'h0000_006F);
        wait_done("two_done");
        check("two_count", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("two_a0", wr_addr[0], 0);
            check("two_d0", wr_data[0], 32'h0000_0013);
            check("two_a1", wr_addr[1], 1);
            check("two_d1", wr_data[1], 32'h0000_006F);
        end
        check("two_done_lat", done_rise_cyc - last_we_cyc, 1);
        check("two_cpurst_at_done", cpu_reset_at_rise, 0);
        check("two_cpurst", cpu_reset, 0);
        check("two_ferr", frame_err, 0);

        // 3: zero-length image, then a stray byte
        pulse_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_done("zero_done");
        check("zero_cpurst", cpu_reset, 0);
        send_byte(8'hAA, 1'b1);
        wait_bits(4 * CPB);
        check("zero_count", wr_addr.size(), 0);
        check("zero_done_hold", done, 1);

        // 4: short glitch before a one-word image
        pulse_reset();
        rx = 1'b0;
        wait_bits(CPB / 4);
        rx = 1'b1;
        wait_bits(3 * CPB);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h1234_5678);
        wait_done("glitch_done");
        check("glitch_count", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("glitch_a0", wr_addr[0], 0);
            check("glitch_d0", wr_data[0], 32'h1234_5678);
        end

        // 5: framing error mid-word, then recovery
        pulse_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_word(32'h8877_6655);
        wait_bits(4 * CPB);
        check("ferr_flag", frame_err, 1);
        check("ferr_count", wr_addr.size(), 0);
        check("ferr_cpurst", cpu_reset, 1);
        check("ferr_done", done, 0);
        pulse_reset();
        check("ferr_clr", frame_err, 0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'hDEAD_BEEF);
        wait_done("rec_done");
        check("rec_count", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("rec_a0", wr_addr[0], 0);
            check("rec_d0", wr_data[0], 32'hDEAD_BEEF);
        end

        // 6: reset after half of the first word
        pulse_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        pulse_reset();
        check_reset_values("midrst");
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h0403_0201);
        wait_done("midrst_done");
        check("midrst_count", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("midrst_a0", wr_addr[0], 0);
            check("midrst_d0", wr_data[0], 32'h0403_0201);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
